sub_bytes_serial: RTL and testbench

//  AES-128 SubBytes stage. Sits directly upstream of the ShiftRows stage and

---
 rtl/sub_bytes_serial.sv | 194 +++++++++++++++++++
 tb/tb_sub_bytes_serial.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_serial.sv
// AES-128 SubBytes stage: BYTES_PER_CYCLE bytes per clock through shared S-boxes, valid/ready on both sides.
// Define SBOX_INV_EN to add the inv_en port and the inverse table (InvSubBytes latched at accept).
module sub_bytes_serial #(
   parameter int BYTES_PER_CYCLE = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
`ifdef SBOX_INV_EN
   output logic         busy,
   input  logic         inv_en
`else
   output logic         busy
`endif
);

   localparam int N  = 16 / BYTES_PER_CYCLE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   generate
      if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
            BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
         $error("sub_bytes_serial: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            w_accept;
   logic            w_last;
   logic [CW-1:0]   r_cnt;
   logic [127:0]    r_work;
   logic [127:0]    w_work_sub;
   logic [127:0]    r_out_state;
   logic            r_in_ready;
   logic            r_out_valid;
   logic            r_busy;
`ifdef SBOX_INV_EN
   logic            r_inv;
`endif

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         p = p ^ (b[i] ? x : 8'h00);
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires)
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] q;
      logic [7:0] r;
      q = a;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         q = gf_mul(q, q);
         r = gf_mul(r, q);
      end
      return r;
   endfunction

   function automatic logic [7:0] aff_fwd(input logic [7:0] b);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

`ifdef SBOX_INV_EN
   function automatic logic [7:0] aff_inv(input logic [7:0] s);
      return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
   endfunction

   function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
      return inv ? gf_inv(aff_inv(b)) : aff_fwd(gf_inv(b));
   endfunction
`else
   function automatic logic [7:0] sub_byte(input logic [7:0] b);
      return aff_fwd(gf_inv(b));
   endfunction
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode, accept strobe and last-pass strobe
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_RUN;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_RUN: begin
            if (r_cnt == CW'(N - 1)) begin
               w_last      = 1'b1;
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_RUN;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_DONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Substitute the bytes of the current pass in place; other bytes pass through
   always_comb begin
      int lsb;
      lsb        = 0;
      w_work_sub = r_work;
      for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
         lsb = 8 * (15 - (int'(r_cnt) * BYTES_PER_CYCLE + j));
`ifdef SBOX_INV_EN
         w_work_sub[lsb +: 8] = sub_byte(r_work[lsb +: 8], r_inv);
`else
         w_work_sub[lsb +: 8] = sub_byte(r_work[lsb +: 8]);
`endif
      end
   end

   // Working register, pass counter, result register and registered handshake flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_work      <= 128'h0;
         r_out_state <= 128'h0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
`ifdef SBOX_INV_EN
         r_inv       <= 1'b0;
`endif
      end else begin
         r_in_ready  <= (w_state_nxt == S_IDLE);
         r_out_valid <= (w_state_nxt == S_DONE);
         r_busy      <= (w_state_nxt != S_IDLE);
         if (w_accept) begin
            r_work <= in_state;
            r_cnt  <= '0;
`ifdef SBOX_INV_EN
            r_inv  <= inv_en;
`endif
         end else if (r_state == S_RUN) begin
            r_work <= w_work_sub;
            r_cnt  <= w_last ? '0 : r_cnt + CW'(1);
         end
         // Result is copied out once so it survives the next accept
         if (w_last) begin
            r_out_state <= w_work_sub;
         end
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign out_state = r_out_state;

endmodule

// File: tb/tb_sub_bytes_serial.sv
// Bench for sub_bytes_serial: three instances (4, 1 and 16 bytes per cycle) checked against
// an S-box model derived from GF(2^8) inversion plus the affine map. Inverse tests need SBOX_INV_EN.
module tb_sub_bytes_serial;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid  [3];
   logic         in_ready  [3];
   logic [127:0] in_state  [3];
   logic         out_valid [3];
   logic         out_ready [3];
   logic [127:0] out_state [3];
   logic         busy      [3];
`ifdef SBOX_INV_EN
   logic         inv_en    [3];
`endif

   int           n_checks = 0;
   int           n_errs   = 0;
   int           cyc      = 0;
   int           acc_cyc  = 0;
   logic [7:0]   fwd_tab  [256];
   logic [7:0]   inv_tab  [256];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int bpc_of(input int d);
      return (d == 0) ? 4 : ((d == 1) ? 1 : 16);
   endfunction

   function automatic int passes(input int d);
      return 16 / bpc_of(d);
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      sub_bytes_serial #(.BYTES_PER_CYCLE(bpc_of(g))) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_state  (in_state[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_state (out_state[g]),
`ifdef SBOX_INV_EN
         .inv_en    (inv_en[g]),
`endif
         .busy      (busy[g])
      );
   end

   // Reference: carry-less product reduced by 0x11b
   function automatic logic [7:0] gmul_ref(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] prod;
      prod = 15'h0;
      for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (15'(a) << i);
      for (int i = 14; i >= 8; i--) if (prod[i]) prod = prod ^ (15'h11b << (i - 8));
      return prod[7:0];
   endfunction

   function automatic logic [7:0] sbox_ref(input logic [7:0] x);
      logic [7:0] b;
      logic [7:0] c;
      logic [7:0] s;
      b = 8'h00;
      c = 8'h63;
      for (int y = 1; y < 256; y++) if (x != 8'h00 && gmul_ref(x, 8'(y)) == 8'h01) b = 8'(y);
      for (int i = 0; i < 8; i++)
         s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ c[i];
      return s;
   endfunction

   task automatic build_tables();
      for (int x = 0; x < 256; x++) fwd_tab[x] = sbox_ref(8'(x));
      for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);
   endtask

   function automatic logic [127:0] model_sub(input logic [127:0] s, input bit inv);
      logic [127:0] r;
      r = s;
      for (int k = 0; k < 16; k++)
         r[127 - 8 * k -: 8] = inv ? inv_tab[s[127 - 8 * k -: 8]] : fwd_tab[s[127 - 8 * k -: 8]];
      return r;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Present s to instance d once it is ready; returns just after the accepting edge
   task automatic send(input int d, input logic [127:0] s, output bit ok);
      int w;
      w = 0;
      while (in_ready[d] !== 1'b1 && w < 50) begin
         @(posedge clk); #1; w++;
      end
      ok = (in_ready[d] === 1'b1);
      in_valid[d] = 1'b1;
      in_state[d] = s;
      @(posedge clk); #1;
      acc_cyc     = cyc;
      in_valid[d] = 1'b0;
      in_state[d] = rnd128();
`ifdef SBOX_INV_EN
      inv_en[d]   = ~inv_en[d];
`endif
   endtask

   task automatic wait_out(input int d, output int lat);
      lat = 0;
      while (out_valid[d] !== 1'b1 && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      if (out_valid[d] !== 1'b1) lat = -1;
   endtask

   task automatic pop(input int d);
      out_ready[d] = 1'b1;
      @(posedge clk); #1;
      out_ready[d] = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         in_valid[d]  = 1'b0;
         out_ready[d] = 1'b0;
         in_state[d]  = 128'h0;
`ifdef SBOX_INV_EN
         inv_en[d]    = 1'b0;
`endif
      end
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         n_checks++;
         if (in_ready[d] !== 1'b1) begin n_errs++; $display("FAIL reset_in_ready[%0d]: got %b want 1", d, in_ready[d]); end
         n_checks++;
         if (out_valid[d] !== 1'b0) begin n_errs++; $display("FAIL reset_out_valid[%0d]: got %b want 0", d, out_valid[d]); end
         n_checks++;
         if (busy[d] !== 1'b0) begin n_errs++; $display("FAIL reset_busy[%0d]: got %b want 0", d, busy[d]); end
         n_checks++;
         if (out_state[d] !== 128'h0) begin n_errs++; $display("FAIL reset_out_state[%0d]: got %h want 0", d, out_state[d]); end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_zero();
      bit ok;
      int lat;
      send(0, 128'h0, ok);
      n_checks++;
      if (!ok) begin n_errs++; $display("FAIL zero_accept: in_ready never high"); end
      wait_out(0, lat);
      n_checks++;
      if (lat != 4) begin n_errs++; $display("FAIL zero_latency: got %0d want 4", lat); end
      n_checks++;
      if (out_state[0] !== {16{8'h63}}) begin n_errs++; $display("FAIL zero_result: got %h want %h", out_state[0], {16{8'h63}}); end
      pop(0);
   endtask

   task automatic test_known_vector();
      bit ok;
      int lat;
      for (int d = 0; d < 3; d++) begin
         send(d, 128'h000102030405060708090a0b0c0d0e0f, ok);
         wait_out(d, lat);
         n_checks++;
         if (lat != passes(d)) begin n_errs++; $display("FAIL kv_latency[bpc=%0d]: got %0d want %0d", bpc_of(d), lat, passes(d)); end
         n_checks++;
         if (out_state[d] !== 128'h637c777bf26b6fc53001672bfed7ab76) begin
            n_errs++; $display("FAIL kv_result[bpc=%0d]: got %h want 637c777bf26b6fc53001672bfed7ab76", bpc_of(d), out_state[d]);
         end
         pop(d);
      end
   endtask

   task automatic test_random();
      bit ok;
      int lat;
      logic [127:0] s;
      logic [127:0] exp;
      for (int d = 0; d < 3; d++) begin
         for (int i = 0; i < 8; i++) begin
            s   = rnd128();
            exp = model_sub(s, 1'b0);
            send(d, s, ok);
            n_checks++;
            if (in_ready[d] !== 1'b0 || busy[d] !== 1'b1) begin
               n_errs++; $display("FAIL rnd_run_flags[bpc=%0d]: in_ready=%b busy=%b want 0/1", bpc_of(d), in_ready[d], busy[d]);
            end
            wait_out(d, lat);
            n_checks++;
            if (lat != passes(d)) begin n_errs++; $display("FAIL rnd_latency[bpc=%0d]: got %0d want %0d", bpc_of(d), lat, passes(d)); end
            n_checks++;
            if (out_state[d] !== exp) begin n_errs++; $display("FAIL rnd_result[bpc=%0d]: in %h got %h want %h", bpc_of(d), s, out_state[d], exp); end
            pop(d);
            n_checks++;
            if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1 || out_state[d] !== exp) begin
               n_errs++; $display("FAIL rnd_after_pop[bpc=%0d]: out_valid=%b in_ready=%b out_state=%h", bpc_of(d), out_valid[d], in_ready[d], out_state[d]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int lat;
      logic [127:0] s;
      logic [127:0] exp;
      logic [127:0] s2;
      s   = rnd128();
      exp = model_sub(s, 1'b0);
      send(0, s, ok);
      wait_out(0, lat);
      for (int i = 0; i < 5; i++) begin
         in_valid[0] = (i % 2 == 0);
         in_state[0] = rnd128();
         @(posedge clk); #1;
         n_checks++;
         if (out_valid[0] !== 1'b1 || out_state[0] !== exp || in_ready[0] !== 1'b0) begin
            n_errs++; $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b out_state=%h want %h", i, out_valid[0], in_ready[0], out_state[0], exp);
         end
      end
      in_valid[0] = 1'b0;
      pop(0);
      n_checks++;
      if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
         n_errs++; $display("FAIL bp_release: in_ready=%b out_valid=%b busy=%b want 1/0/0", in_ready[0], out_valid[0], busy[0]);
      end
      out_ready[0] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      out_ready[0] = 1'b0;
      n_checks++;
      if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || out_state[0] !== exp) begin
         n_errs++; $display("FAIL bp_idle_ready: in_ready=%b out_valid=%b out_state=%h", in_ready[0], out_valid[0], out_state[0]);
      end
      s2 = rnd128();
      send(0, s2, ok);
      n_checks++;
      if (out_state[0] !== exp) begin n_errs++; $display("FAIL bp_result_held: got %h want %h", out_state[0], exp); end
      wait_out(0, lat);
      n_checks++;
      if (out_state[0] !== model_sub(s2, 1'b0)) begin n_errs++; $display("FAIL bp_next_result: got %h want %h", out_state[0], model_sub(s2, 1'b0)); end
      pop(0);
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit seen;
      int lat;
      logic [127:0] s;
      send(0, rnd128(), ok);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      n_checks++;
      if (in_ready[0] !== 1'b1 || busy[0] !== 1'b0 || out_state[0] !== 128'h0) begin
         n_errs++; $display("FAIL mid_reset_state: in_ready=%b busy=%b out_state=%h", in_ready[0], busy[0], out_state[0]);
      end
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (out_valid[0] === 1'b1) seen = 1'b1;
      end
      n_checks++;
      if (seen) begin n_errs++; $display("FAIL mid_reset_no_output: out_valid seen 1 want never"); end
      s = rnd128();
      send(0, s, ok);
      wait_out(0, lat);
      n_checks++;
      if (lat != 4 || out_state[0] !== model_sub(s, 1'b0)) begin
         n_errs++; $display("FAIL mid_reset_recover: lat=%0d got %h want %h", lat, out_state[0], model_sub(s, 1'b0));
      end
      pop(0);
   endtask

   task automatic test_back_to_back();
      bit ok;
      int lat;
      int a1;
      logic [127:0] s;
      for (int d = 0; d < 3; d++) begin
         send(d, rnd128(), ok);
         a1 = acc_cyc;
         wait_out(d, lat);
         pop(d);
         s = rnd128();
         send(d, s, ok);
         n_checks++;
         if (acc_cyc - a1 != passes(d) + 2) begin
            n_errs++; $display("FAIL b2b_spacing[bpc=%0d]: got %0d want %0d", bpc_of(d), acc_cyc - a1, passes(d) + 2);
         end
         wait_out(d, lat);
         n_checks++;
         if (out_state[d] !== model_sub(s, 1'b0)) begin n_errs++; $display("FAIL b2b_result[bpc=%0d]: got %h want %h", bpc_of(d), out_state[d], model_sub(s, 1'b0)); end
         pop(d);
      end
   endtask

`ifdef SBOX_INV_EN
   task automatic test_inverse();
      bit ok;
      int lat;
      logic [127:0] s;
      inv_en[0] = 1'b1;
      send(0, {16{8'h63}}, ok);
      wait_out(0, lat);
      n_checks++;
      if (out_state[0] !== 128'h0) begin n_errs++; $display("FAIL inv_63: got %h want 0", out_state[0]); end
      pop(0);
      inv_en[0] = 1'b1;
      send(0, {16{8'h53}}, ok);
      wait_out(0, lat);
      n_checks++;
      if (out_state[0] !== {16{8'h50}}) begin n_errs++; $display("FAIL inv_53: got %h want %h", out_state[0], {16{8'h50}}); end
      pop(0);
      inv_en[0] = 1'b0;
      send(0, {16{8'h53}}, ok);
      wait_out(0, lat);
      n_checks++;
      if (out_state[0] !== {16{8'hed}}) begin n_errs++; $display("FAIL fwd_53: got %h want %h", out_state[0], {16{8'hed}}); end
      pop(0);
      for (int d = 0; d < 3; d++) begin
         s = rnd128();
         inv_en[d] = 1'b1;
         send(d, s, ok);
         wait_out(d, lat);
         n_checks++;
         if (out_state[d] !== model_sub(s, 1'b1)) begin n_errs++; $display("FAIL inv_rnd[bpc=%0d]: got %h want %h", bpc_of(d), out_state[d], model_sub(s, 1'b1)); end
         pop(d);
      end
   endtask
`endif

   initial begin
      build_tables();
      test_reset();
      test_zero();
      test_known_vector();
      test_random();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
`ifdef SBOX_INV_EN
      test_inverse();
`endif
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
